vex_lane_pipe: RTL and testbench

- Vector execute stage sitting directly downstream of the banked vector register file (VRF), which it also drives.
- Accepts one vector instruction per handshake and sequences the VRF slice reads using load_en.
- Computes per-element integer results in a 2-stage lane pipeline.
- Drives the VRF write port (write_en, vd_data) for exactly one contiguous burst per instruction, so the VRF's internal slice counters stay aligned.

---
 rtl/vex_lane_pipe_if.sv | 51 +++++
 rtl/vex_lane_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_vex_lane_pipe.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vex_lane_pipe_if.sv
// Issue/VRF bundle for the vector execute stage: instruction handshake,
// VRF read data coming in, and VRF control/writeback going out.
interface vex_lane_pipe_if #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 12
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int VW = LANES * DATA_WIDTH;

    logic          issue_valid;
    logic          issue_ready;
    logic [2:0]    issue_op;
    logic [1:0]    issue_vsew;
    logic [7:0]    issue_vl;
    logic [3:0]    issue_slices;
    logic [AW-1:0] issue_vs1;
    logic [AW-1:0] issue_vs2;
    logic [AW-1:0] issue_vd;
    logic [VW-1:0] vs1_data;
    logic [VW-1:0] vs2_data;
    logic [VW-1:0] vs3_data;
    logic [AW-1:0] vs1_addr_o;
    logic [AW-1:0] vs2_addr_o;
    logic [AW-1:0] vd_addr_o;
    logic [1:0]    vsew_o;
    logic [7:0]    vl_o;
    logic [3:0]    max_load_cnt;
    logic [3:0]    max_write_cnt;
    logic          reduction;
    logic          load_en;
    logic          write_en;
    logic [VW-1:0] vd_data;
    logic          busy;

    modport slave (
        input  issue_valid, issue_op, issue_vsew, issue_vl, issue_slices,
               issue_vs1, issue_vs2, issue_vd, vs1_data, vs2_data, vs3_data,
        output issue_ready, vs1_addr_o, vs2_addr_o, vd_addr_o, vsew_o, vl_o,
               max_load_cnt, max_write_cnt, reduction, load_en, write_en,
               vd_data, busy
    );

    modport master (
        output issue_valid, issue_op, issue_vsew, issue_vl, issue_slices,
               issue_vs1, issue_vs2, issue_vd, vs1_data, vs2_data, vs3_data,
        input  issue_ready, vs1_addr_o, vs2_addr_o, vd_addr_o, vsew_o, vl_o,
               max_load_cnt, max_write_cnt, reduction, load_en, write_en,
               vd_data, busy
    );
endinterface

// File: rtl/vex_lane_pipe.sv
// Vector execute stage: sequences N VRF slice reads, runs a 2-stage lane
// pipeline, and writes back one contiguous N-cycle burst per instruction.
module vex_lane_pipe #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 12
) (
    input  logic             clk,
    input  logic             rstn,
    vex_lane_pipe_if.slave   bus
);
    localparam int AW = $clog2(NUM_REGS);
    localparam int VW = LANES * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t        state_q;
    logic [2:0]    cnt_q;
    logic [3:0]    n_q;
    logic [2:0]    op_q;
    logic [1:0]    vsew_q;
    logic [7:0]    vl_q;
    logic [AW-1:0] vs1_addr_q, vs2_addr_q, vd_addr_q;
    logic          red_q;
    logic          load_en_q;

    logic          s1_valid_q;
    logic [2:0]    s1_op_q;
    logic [1:0]    s1_vsew_q;
    logic [7:0]    s1_vl_q;
    logic [VW-1:0] s1_a_q, s1_b_q, s1_c_q;
    logic          write_en_q;
    logic [VW-1:0] vd_q;
    logic [VW-1:0] result_d;
    logic [VW-1:0] lane_vec;
    logic [VW-1:0] red_vec;
    logic [31:0]   red_acc;
    logic [31:0]   wmask;

    function automatic logic [3:0] eff_slices(input logic [2:0] op, input logic [3:0] sl);
        if (op == 3'd6 || sl == 4'd0) return 4'd1;
        if (sl > 4'd8)                return 4'd8;
        return sl;
    endfunction

    // Element is placed at the top of the word so add/sub/mul wrap and signed
    // compares work on the element width without separate per-width datapaths.
    function automatic logic [31:0] elem_alu(input logic [2:0] op, input logic [4:0] sh,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        logic [31:0] ah, bh, ch, r;
        ah = a << sh;
        bh = b << sh;
        ch = c << sh;
        case (op)
            3'd0:    r = ah + bh;
            3'd1:    r = ah - bh;
            3'd2:    r = ah * b;
            3'd3:    r = ah * b + ch;
            3'd4:    r = ($signed(ah) < $signed(bh)) ? ah : bh;
            3'd5:    r = ($signed(ah) > $signed(bh)) ? ah : bh;
            default: r = ch;
        endcase
        return r >> sh;
    endfunction

    function automatic logic [31:0] lane_alu(input logic [2:0] op, input logic [1:0] sew,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] c);
        logic [31:0] r, t;
        r = c;
        case (sew)
            2'd0: for (int e = 0; e < 4; e++) begin
                t = elem_alu(op, 5'd24, {24'b0, a[8*e +: 8]}, {24'b0, b[8*e +: 8]},
                             {24'b0, c[8*e +: 8]});
                r[8*e +: 8] = t[7:0];
            end
            2'd1: for (int e = 0; e < 2; e++) begin
                t = elem_alu(op, 5'd16, {16'b0, a[16*e +: 16]}, {16'b0, b[16*e +: 16]},
                             {16'b0, c[16*e +: 16]});
                r[16*e +: 16] = t[15:0];
            end
            2'd2:    r = elem_alu(op, 5'd0, a, b, c);
            default: r = c;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            n_q        <= '0;
            op_q       <= '0;
            vsew_q     <= '0;
            vl_q       <= '0;
            vs1_addr_q <= '0;
            vs2_addr_q <= '0;
            vd_addr_q  <= '0;
            red_q      <= 1'b0;
            load_en_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.issue_valid) begin
                    n_q        <= eff_slices(bus.issue_op, bus.issue_slices);
                    op_q       <= bus.issue_op;
                    vsew_q     <= bus.issue_vsew;
                    vl_q       <= bus.issue_vl;
                    vs1_addr_q <= bus.issue_vs1;
                    vs2_addr_q <= bus.issue_vs2;
                    vd_addr_q  <= bus.issue_vd;
                    red_q      <= (bus.issue_op == 3'd6);
                    cnt_q      <= '0;
                    load_en_q  <= 1'b1;
                    state_q    <= LOAD;
                end
                LOAD: if ({1'b0, cnt_q} == n_q - 4'd1) begin
                    load_en_q <= 1'b0;
                    state_q   <= DRAIN;
                end else begin
                    cnt_q <= cnt_q + 3'd1;
                end
                // Last write is the one with no stage-1 data behind it
                DRAIN: if (write_en_q && !s1_valid_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_vsew_q  <= '0;
            s1_vl_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= '0;
            write_en_q <= 1'b0;
            vd_q       <= '0;
        end else begin
            s1_valid_q <= load_en_q;
            if (load_en_q) begin
                s1_op_q   <= op_q;
                s1_vsew_q <= vsew_q;
                s1_vl_q   <= vl_q;
                s1_a_q    <= bus.vs1_data;
                s1_b_q    <= bus.vs2_data;
                s1_c_q    <= bus.vs3_data;
            end
            write_en_q <= s1_valid_q;
            if (s1_valid_q) vd_q <= result_d;
        end
    end

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_vec[gi*DATA_WIDTH +: DATA_WIDTH] =
                lane_alu(s1_op_q, s1_vsew_q, s1_a_q[gi*DATA_WIDTH +: DATA_WIDTH],
                         s1_b_q[gi*DATA_WIDTH +: DATA_WIDTH], s1_c_q[gi*DATA_WIDTH +: DATA_WIDTH]);
        end
    endgenerate

    // Reduction walks elements in lane-major order; only slice 0 is ever loaded
    always_comb begin
        int epl;
        int w;
        case (s1_vsew_q)
            2'd0:    begin wmask = 32'h0000_00FF; epl = 4; w = 8;  end
            2'd1:    begin wmask = 32'h0000_FFFF; epl = 2; w = 16; end
            default: begin wmask = 32'hFFFF_FFFF; epl = 1; w = 32; end
        endcase
        red_acc = s1_a_q[31:0] & wmask;
        for (int l = 0; l < LANES; l++) begin
            for (int e = 0; e < 4; e++) begin
                if (e < epl && (l * epl + e) < int'(s1_vl_q))
                    red_acc = red_acc + ((s1_b_q[l*DATA_WIDTH +: 32] >> (e * w)) & wmask);
            end
        end
        red_vec        = '0;
        red_vec[31:0]  = red_acc & wmask;
    end

    always_comb begin
        if (s1_vsew_q == 2'd3 || s1_op_q == 3'd7) result_d = s1_c_q;
        else if (s1_op_q == 3'd6)                 result_d = red_vec;
        else                                      result_d = lane_vec;
    end

    assign bus.issue_ready   = rstn && (state_q == IDLE);
    assign bus.busy          = (state_q != IDLE);
    assign bus.load_en       = load_en_q;
    assign bus.write_en      = write_en_q;
    assign bus.vd_data       = vd_q;
    assign bus.vs1_addr_o    = vs1_addr_q;
    assign bus.vs2_addr_o    = vs2_addr_q;
    assign bus.vd_addr_o     = vd_addr_q;
    assign bus.vsew_o        = vsew_q;
    assign bus.vl_o          = vl_q;
    assign bus.max_load_cnt  = n_q;
    assign bus.max_write_cnt = n_q;
    assign bus.reduction     = red_q;
endmodule

// File: tb/tb_vex_lane_pipe.sv
// Directed + random bench for vex_lane_pipe; a per-element arithmetic model
// predicts every writeback slice and the cycle-exact handshake/burst timing.
module tb_vex_lane_pipe;
    localparam int LANES = 4;
    localparam int DW    = 32;
    localparam int VW    = LANES * DW;

    logic clk;
    logic rstn;
    int   errors;
    int   checks;

    logic [VW-1:0] m1 [8];
    logic [VW-1:0] m2 [8];
    logic [VW-1:0] m3 [8];

    vex_lane_pipe_if #(.LANES(LANES), .DATA_WIDTH(DW), .NUM_REGS(12)) bus ();

    vex_lane_pipe #(.LANES(LANES), .DATA_WIDTH(DW), .NUM_REGS(12)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic longint signed to_signed(input longint unsigned x, input int w);
        if (x >= (64'd1 << (w - 1))) return longint'(x) - longint'(64'd1 << w);
        return longint'(x);
    endfunction

    // Reference: element i sits at bit i*w of the vector (lane-major order)
    function automatic logic [VW-1:0] model(input logic [2:0] op, input logic [1:0] sew,
                                            input logic [7:0] vl, input logic [VW-1:0] a,
                                            input logic [VW-1:0] b, input logic [VW-1:0] c);
        logic [VW-1:0] r, t;
        longint unsigned mask, x, y, z, res;
        int w, nel;
        if (sew == 2'd3 || op == 3'd7) return c;
        w    = 8 << sew;
        nel  = VW / w;
        mask = (64'd1 << w) - 64'd1;
        r    = '0;
        if (op == 3'd6) begin
            res = longint'(a[31:0]) & mask;
            for (int i = 0; i < nel; i++)
                if (i < int'(vl)) res += longint'((b >> (i * w)) & VW'(mask));
            t = VW'(res & mask);
            return t;
        end
        for (int i = 0; i < nel; i++) begin
            x = longint'((a >> (i * w)) & VW'(mask));
            y = longint'((b >> (i * w)) & VW'(mask));
            z = longint'((c >> (i * w)) & VW'(mask));
            case (op)
                3'd0:    res = x + y;
                3'd1:    res = x - y;
                3'd2:    res = x * y;
                3'd3:    res = x * y + z;
                3'd4:    res = (to_signed(x, w) < to_signed(y, w)) ? x : y;
                default: res = (to_signed(x, w) > to_signed(y, w)) ? x : y;
            endcase
            t = VW'(res & mask);
            r = r | (t << (i * w));
        end
        return r;
    endfunction

    // Starts at a negedge; ends at the negedge of t0+N+3 (block idle again).
    task automatic run_op(input logic [2:0] op, input logic [1:0] sew, input logic [7:0] vl,
                          input logic [3:0] sl, input bit keep);
        logic [VW-1:0] exp [8];
        logic [3:0] a1, a2, ad;
        int n;
        n  = (op == 3'd6 || sl == 4'd0) ? 1 : (sl > 4'd8 ? 8 : int'(sl));
        for (int s = 0; s < n; s++) exp[s] = model(op, sew, vl, m1[s], m2[s], m3[s]);
        a1 = 4'($urandom_range(0, 11));
        a2 = 4'($urandom_range(0, 11));
        ad = 4'($urandom_range(0, 11));
        bus.issue_op     = op;
        bus.issue_vsew   = sew;
        bus.issue_vl     = vl;
        bus.issue_slices = sl;
        bus.issue_vs1    = a1;
        bus.issue_vs2    = a2;
        bus.issue_vd     = ad;
        bus.issue_valid  = 1'b1;
        #1 chk("ready_at_issue", VW'(bus.issue_ready), VW'(1));
        $display("issue op=%0d sew=%0d vl=%0d slices=%0d N=%0d", op, sew, vl, sl, n);
        for (int c = 1; c <= n + 3; c++) begin
            @(negedge clk);
            if (!keep) bus.issue_valid = 1'b0;
            if (c <= n) begin
                bus.vs1_data = m1[c-1];
                bus.vs2_data = m2[c-1];
                bus.vs3_data = m3[c-1];
            end else begin
                bus.vs1_data = rand_vec();
                bus.vs2_data = rand_vec();
                bus.vs3_data = rand_vec();
            end
            chk("load_en",  VW'(bus.load_en),     VW'(c <= n));
            chk("write_en", VW'(bus.write_en),    VW'(c >= 3 && c <= n + 2));
            chk("busy",     VW'(bus.busy),        VW'(c <= n + 2));
            chk("ready",    VW'(bus.issue_ready), VW'(c == n + 3));
            if (c >= 3 && c <= n + 2) chk("vd_data", bus.vd_data, exp[c-3]);
            if (c == 1 || c == n + 3) begin
                chk("vs1_addr_o",    VW'(bus.vs1_addr_o),    VW'(a1));
                chk("vs2_addr_o",    VW'(bus.vs2_addr_o),    VW'(a2));
                chk("vd_addr_o",     VW'(bus.vd_addr_o),     VW'(ad));
                chk("vsew_o",        VW'(bus.vsew_o),        VW'(sew));
                chk("vl_o",          VW'(bus.vl_o),          VW'(vl));
                chk("max_load_cnt",  VW'(bus.max_load_cnt),  VW'(n));
                chk("max_write_cnt", VW'(bus.max_write_cnt), VW'(n));
                chk("reduction",     VW'(bus.reduction),     VW'(op == 3'd6));
            end
        end
    endtask

    task automatic fill_random();
        for (int s = 0; s < 8; s++) begin
            m1[s] = rand_vec();
            m2[s] = rand_vec();
            m3[s] = rand_vec();
        end
    endtask

    initial begin
        logic [2:0] rop;
        logic [1:0] rsew;
        errors = 0;
        checks = 0;
        rstn = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_op     = '0;
        bus.issue_vsew   = '0;
        bus.issue_vl     = '0;
        bus.issue_slices = '0;
        bus.issue_vs1    = '0;
        bus.issue_vs2    = '0;
        bus.issue_vd     = '0;
        bus.vs1_data     = '0;
        bus.vs2_data     = '0;
        bus.vs3_data     = '0;
        repeat (3) @(negedge clk);
        chk("rst_load_en",  VW'(bus.load_en),      '0);
        chk("rst_write_en", VW'(bus.write_en),     '0);
        chk("rst_busy",     VW'(bus.busy),         '0);
        chk("rst_vd_data",  bus.vd_data,           '0);
        chk("rst_vl_o",     VW'(bus.vl_o),         '0);
        chk("rst_maxcnt",   VW'(bus.max_load_cnt), '0);
        chk("rst_red",      VW'(bus.reduction),    '0);
        rstn = 1'b1;
        #1 chk("rst_ready", VW'(bus.issue_ready), VW'(1));
        @(negedge clk);

        // ADD bytes 0x7F + 0x02 wraps to 0x81
        for (int s = 0; s < 8; s++) begin
            m1[s] = {16{8'h7F}};
            m2[s] = {16{8'h02}};
            m3[s] = rand_vec();
        end
        run_op(3'd0, 2'd0, 8'd8, 4'd2, 1'b0);

        // MACC halves 0x0100*0x0100 + 5 keeps low 16 bits
        m1[0] = {8{16'h0100}};
        m2[0] = {8{16'h0100}};
        m3[0] = {8{16'h0005}};
        run_op(3'd3, 2'd1, 8'd8, 4'd1, 1'b0);

        // REDSUM: 10 + 1+2+3+4+5 = 0x19
        fill_random();
        for (int i = 0; i < 16; i++) m2[0][i*8 +: 8] = 8'(i + 1);
        m1[0][7:0] = 8'd10;
        run_op(3'd6, 2'd0, 8'd5, 4'd4, 1'b0);

        fill_random();
        run_op(3'd1, 2'd2, 8'd32, 4'd12, 1'b0);
        fill_random();
        run_op(3'd2, 2'd1, 8'd3, 4'd0, 1'b0);

        // issue_valid held through a 3-slice op: second accept right after last write
        fill_random();
        run_op(3'd5, 2'd0, 8'd12, 4'd3, 1'b1);
        run_op(3'd4, 2'd0, 8'd12, 4'd3, 1'b0);

        // Reset mid-LOAD aborts the instruction
        fill_random();
        bus.issue_op     = 3'd0;
        bus.issue_vsew   = 2'd2;
        bus.issue_slices = 4'd4;
        bus.issue_valid  = 1'b1;
        @(negedge clk);
        bus.issue_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("abort_load_en",  VW'(bus.load_en),  '0);
        chk("abort_write_en", VW'(bus.write_en), '0);
        chk("abort_busy",     VW'(bus.busy),     '0);
        @(negedge clk);
        rstn = 1'b1;
        #1 chk("abort_ready", VW'(bus.issue_ready), VW'(1));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_write", VW'(bus.write_en), '0);
            chk("abort_no_load",  VW'(bus.load_en),  '0);
        end
        run_op(3'd0, 2'd0, 8'd16, 4'd2, 1'b0);

        for (int k = 0; k < 30; k++) begin
            fill_random();
            rop  = 3'($urandom_range(0, 7));
            rsew = 2'($urandom_range(0, (rop == 3'd6) ? 2 : 3));
            run_op(rop, rsew, 8'($urandom_range(0, 40)), 4'($urandom_range(0, 15)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
